sram: RTL and testbench
=======================

Name: sram

Overview:
- Synchronous dual-port (1 read, 1 write) block RAM backing the L1 data cache data array.
- Each entry is one full cache block of WIDTH bits, split into WIDTH/WORDSIZE words, each with its own write enable.
- Read data is registered with a fixed, parameterised latency.
- The cache controller drives registered addresses and counts DELAY cycles before consuming readData.

Parameters:
- WORDSIZE, 64, bits per word; write-enable granularity.
- WIDTH, 512, bits per entry (one cache block). Must be a multiple of WORDSIZE.
- LOGDEPTH, 9, log2 of the entry count (512 entries).
- DELAY, 1, read pipeline stages. Must be ≥1.
- Derived: WORDS = WIDTH/WORDSIZE (8); DEPTH = 2^LOGDEPTH.

Ports:
- clk  input  1  clock; all sampling on rising edge.
- reset  input  1  asynchronous, active-low reset.
- readAddr  input  LOGDEPTH  read entry index.
- readData  output  WIDTH  registered read data.
- writeAddr  input  LOGDEPTH  write entry index.
- writeData  input  WIDTH  write data; word i = bits [i*WORDSIZE +: WORDSIZE].
- writeEnable  input  WORDS  bit i enables write of word i.

Behaviour:
- Reset (reset=0, asynchronous):
  - readData and all internal read-pipeline stages clear to 0 immediately.
  - Memory array contents are not cleared; they are retained across reset.
  - No writes occur while reset is low.
  - On deassertion, operation resumes at the next rising edge.
- Write:
  - At each rising edge with reset=1, for every i with writeEnable[i]=1, mem[writeAddr] word i <= writeData word i.
  - Words with writeEnable[i]=0 are unchanged.
  - writeEnable=0 means no write.
  - Partial-word writes are not supported.
- Read:
  - Always active; there is no read enable.
  - readAddr is sampled every rising edge.
  - Stage 1 captures mem[readAddr]. Stages 2..DELAY shift the value forward.
  - readData is the last stage.
  - With DELAY=1: readData after edge N equals the entry addressed by readAddr at edge N.
  - With DELAY=d: the data appears d-1 edges later.
  - readData holds its value as long as readAddr and the addressed contents are stable.
- Read/write collision (readAddr==writeAddr at the same edge) is write-through per word:
  - Words being written that cycle return the new writeData.
  - Other words return the old stored contents.
  - Collisions on different addresses have no interaction.
- Back-to-back operation:
  - A new read and a new write are accepted every cycle. No stalls, no busy signal.
- Addresses are LOGDEPTH bits wide, so every value is in range; there is no out-of-range case.
- Never-written entries read as X in simulation; this is not a functional requirement.
- Reset asserted mid-read: the pipeline is flushed to 0, and data for reads issued before reset is discarded.
- Reset asserted mid-write: an edge with reset=0 performs no write.

Test Plan:
1. Reset & idle: reset=0 with arbitrary readAddr → readData=0 immediately (asynchronous). Release reset → no spurious writes.
2. Full-entry write then read:
   - Write entry 0x05 with writeEnable=8'hFF and data pattern P (word i = 64'h1111_1111_1111_1111*i).
   - Next cycle set readAddr=0x05 → readData==P one edge later (DELAY=1).
3. Per-word enable:
   - Entry 0x10 holds all-ones.
   - Write all-zeros with writeEnable=8'b0000_0101 → words 0 and 2 read 0; words 1 and 3–7 read 64'hFFFF_FFFF_FFFF_FFFF.
4. Collision:
   - Entry 0x20 holds A (all 0xAA).
   - At the same edge: readAddr=writeAddr=0x20, writeData B (all 0x55), writeEnable=8'h0F.
   - → readData words 0–3 = 0x55.., words 4–7 = 0xAA...
5. Pipelined streaming:
   - Write entries 0..7 with distinct data.
   - Then readAddr = 0,1,..,7 on consecutive cycles → readData sequence matches, one value per cycle, DELAY cycles behind.
   - Repeat with DELAY=3.
6. Reset mid-operation:
   - Issue a read, then assert reset before data emerges (DELAY=3) → readData=0.
   - After release, re-read the same entry → original contents (array retained).

Source files
------------

// File: rtl/sram.sv
// One-read/one-write block RAM for the L1 data-cache data array: per-word write
// enables, per-word write-through on same-address collisions, DELAY-stage read pipeline.
module sram #(
  parameter int WORDSIZE = 64,
  parameter int WIDTH    = 512,
  parameter int LOGDEPTH = 9,
  parameter int DELAY    = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [LOGDEPTH-1:0]       readAddr,
  output logic [WIDTH-1:0]          readData,
  input  logic [LOGDEPTH-1:0]       writeAddr,
  input  logic [WIDTH-1:0]          writeData,
  input  logic [WIDTH/WORDSIZE-1:0] writeEnable
);

  localparam int WORDS = WIDTH / WORDSIZE;
  localparam int DEPTH = 1 << LOGDEPTH;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_fwd;
  logic [WIDTH-1:0] rd_p [DELAY];

  // Write-through only for the words actually being written to the same entry.
  always_comb begin
    rd_fwd = mem[readAddr];
    for (int i = 0; i < WORDS; i++) begin
      if (writeEnable[i] && (readAddr == writeAddr)) begin
        rd_fwd[i*WORDSIZE +: WORDSIZE] = writeData[i*WORDSIZE +: WORDSIZE];
      end
    end
  end

  // Stage p0 captures the array; later stages shift. The array itself is never
  // cleared, so its contents survive reset; writes are suppressed while reset is low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < DELAY; s++) begin
        rd_p[s] <= '0;
      end
    end else begin
      for (int i = 0; i < WORDS; i++) begin
        if (writeEnable[i]) begin
          mem[writeAddr][i*WORDSIZE +: WORDSIZE] <= writeData[i*WORDSIZE +: WORDSIZE];
        end
      end
      rd_p[0] <= rd_fwd;
      for (int s = 1; s < DELAY; s++) begin
        rd_p[s] <= rd_p[s-1];
      end
    end
  end

  assign readData = rd_p[DELAY-1];

endmodule

// File: tb/tb_sram.sv
// Directed bench for sram: one DELAY=1 and one DELAY=3 instance share the same
// stimulus; expected values are hand-built constants.
module tb_sram;

  localparam int WORDSIZE = 64;
  localparam int WIDTH    = 512;
  localparam int LOGDEPTH = 9;
  localparam int WORDS    = WIDTH / WORDSIZE;

  logic                clk = 1'b0;
  logic                reset;
  logic [LOGDEPTH-1:0] readAddr;
  logic [LOGDEPTH-1:0] writeAddr;
  logic [WIDTH-1:0]    writeData;
  logic [WORDS-1:0]    writeEnable;
  logic [WIDTH-1:0]    rd_d1;
  logic [WIDTH-1:0]    rd_d3;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  sram #(.WORDSIZE(WORDSIZE), .WIDTH(WIDTH), .LOGDEPTH(LOGDEPTH), .DELAY(1)) u_dut1 (
    .clk(clk), .reset(reset), .readAddr(readAddr), .readData(rd_d1),
    .writeAddr(writeAddr), .writeData(writeData), .writeEnable(writeEnable)
  );

  sram #(.WORDSIZE(WORDSIZE), .WIDTH(WIDTH), .LOGDEPTH(LOGDEPTH), .DELAY(3)) u_dut3 (
    .clk(clk), .reset(reset), .readAddr(readAddr), .readData(rd_d3),
    .writeAddr(writeAddr), .writeData(writeData), .writeEnable(writeEnable)
  );

  task automatic check(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [LOGDEPTH-1:0] a, input logic [WIDTH-1:0] d,
                          input logic [WORDS-1:0] we);
    writeAddr   = a;
    writeData   = d;
    writeEnable = we;
    tick();
    writeEnable = '0;
  endtask

  function automatic logic [WIDTH-1:0] stream_val(input int k);
    logic [WORDSIZE-1:0] w;
    w = {56'hA5A5_5A5A_0F0F_F0, k[7:0]};
    return {WORDS{w}};
  endfunction

  logic [WIDTH-1:0] pat_p, ones, mixed, aa, b55, coll, kval;

  initial begin
    ones  = '1;
    aa    = {(WIDTH/8){8'hAA}};
    b55   = {(WIDTH/8){8'h55}};
    kval  = {WORDS{64'h0123_4567_89AB_CDEF}};
    for (int i = 0; i < WORDS; i++) begin
      pat_p[i*WORDSIZE +: WORDSIZE] = 64'h1111_1111_1111_1111 * i;
    end
    // words 0 and 2 cleared, the rest still all-ones
    mixed = ones;
    mixed[0*WORDSIZE +: WORDSIZE] = '0;
    mixed[2*WORDSIZE +: WORDSIZE] = '0;
    // words 0-3 from the colliding write, words 4-7 from the old contents
    coll = {aa[WIDTH-1:WIDTH/2], b55[WIDTH/2-1:0]};

    reset = 1'b1; readAddr = 9'h1AB; writeAddr = '0; writeData = '0; writeEnable = '0;
    #2 reset = 1'b0;
    #1;
    check("reset_async_d1", rd_d1, '0);
    check("reset_async_d3", rd_d3, '0);
    tick();
    check("reset_hold_d1", rd_d1, '0);
    reset = 1'b1;

    // Full-entry write then read
    do_write(9'h05, pat_p, 8'hFF);
    readAddr = 9'h05;
    tick();
    check("full_rd_d1", rd_d1, pat_p);
    check("full_rd_d3_early", rd_d3, '0);
    tick(); tick();
    check("full_rd_d3", rd_d3, pat_p);

    // writeEnable=0 must leave the entry alone
    do_write(9'h05, {WORDS{64'hDEAD_BEEF_DEAD_BEEF}}, 8'h00);
    tick();
    check("we0_no_write", rd_d1, pat_p);

    // Per-word enables
    do_write(9'h10, ones, 8'hFF);
    do_write(9'h10, '0, 8'b0000_0101);
    readAddr = 9'h10;
    tick();
    check("word_en_d1", rd_d1, mixed);
    tick(); tick();
    check("word_en_d3", rd_d3, mixed);

    // Same-address collision, write-through per word
    do_write(9'h20, aa, 8'hFF);
    readAddr = 9'h20;
    do_write(9'h20, b55, 8'h0F);
    check("collide_d1", rd_d1, coll);
    tick(); tick();
    check("collide_d3", rd_d3, coll);
    check("collide_stored", rd_d1, coll);

    // Streaming reads, one per cycle
    for (int k = 0; k < 8; k++) do_write(k[LOGDEPTH-1:0], stream_val(k), 8'hFF);
    for (int c = 0; c < 10; c++) begin
      readAddr = (c < 8) ? c[LOGDEPTH-1:0] : 9'h05;
      tick();
      if (c < 8) check($sformatf("stream_d1_%0d", c), rd_d1, stream_val(c));
      if (c >= 2) check($sformatf("stream_d3_%0d", c - 2), rd_d3, stream_val(c - 2));
    end

    // Reset mid-read and mid-write; array contents must survive
    do_write(9'h30, kval, 8'hFF);
    readAddr = 9'h30;
    tick();
    #2 reset = 1'b0;
    #1;
    check("midrd_flush_d3", rd_d3, '0);
    check("midrd_flush_d1", rd_d1, '0);
    writeAddr = 9'h30; writeData = ones; writeEnable = 8'hFF;
    tick(); tick();
    check("midrst_hold_d3", rd_d3, '0);
    writeEnable = '0;
    reset = 1'b1;
    tick();
    check("retain_d1", rd_d1, kval);
    check("retain_d3_early", rd_d3, '0);
    tick(); tick();
    check("retain_d3", rd_d3, kval);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
